// File: rtl/timer_gen2_pkg.sv
// Shared register-map constants and helpers for the gen2 Avalon interval timer.
package timer_gen2_pkg;

  localparam logic [3:0] ADDR_STATUS  = 4'd0;
  localparam logic [3:0] ADDR_CONTROL = 4'd1;
  localparam logic [3:0] ADDR_PERIOD0 = 4'd2;

  localparam int TO_BIT    = 0;
  localparam int RUN_BIT   = 1;
  localparam int ITO_BIT   = 0;
  localparam int CONT_BIT  = 1;
  localparam int START_BIT = 2;
  localparam int STOP_BIT  = 3;

  typedef struct packed {
    logic run;
    logic to;
  } status_t;

  function automatic int calc_nw(input int count_w, input int data_w);
    return count_w / data_w;
  endfunction

  // Snapshot words follow directly after the NW period words.
  function automatic logic [3:0] addr_snap0(input int nw);
    return ADDR_PERIOD0 + 4'(nw);
  endfunction

endpackage

// File: rtl/timer_gen2_counter.sv
// Loadable down-counter with enable and a zero flag; load has priority over counting.
module timer_gen2_counter #(
  parameter int                 COUNT_W     = 32,
  parameter logic [COUNT_W-1:0] RESET_VALUE = '0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load,
  input  logic               enable,
  input  logic [COUNT_W-1:0] load_value,
  output logic [COUNT_W-1:0] count,
  output logic               zero
);

  localparam logic [COUNT_W-1:0] ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

  logic [COUNT_W-1:0] count_r;

  // Counter state: reload wins over decrement, otherwise hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_r <= RESET_VALUE;
    end else if (load) begin
      count_r <= load_value;
    end else if (enable) begin
      count_r <= count_r - ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;
  assign zero  = (count_r == '0);

endmodule

// File: rtl/avalon_interval_timer_gen2.sv
// Avalon-MM interval timer: register file, read mux, run/timeout control around a down-counter.
module avalon_interval_timer_gen2
  import timer_gen2_pkg::*;
#(
  parameter int          COUNT_W      = 32,
  parameter int          DATA_W       = 16,
  parameter logic [63:0] RESET_PERIOD = 64'd49999,
  parameter bit          FIXED_PERIOD = 1'b0,
  parameter bit          ALWAYS_RUN   = 1'b0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [3:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] readdata,
  output logic              irq,
  output logic              tick_out
);

  localparam int                 NW             = calc_nw(COUNT_W, DATA_W);
  localparam logic [3:0]         ADDR_SNAP0     = addr_snap0(NW);
  localparam logic [3:0]         ADDR_SNAP_LAST = ADDR_SNAP0 + 4'(NW - 1);
  localparam logic [COUNT_W-1:0] RST_PERIOD     = RESET_PERIOD[COUNT_W-1:0];

  logic               wr_s, stat_we_s, ctrl_we_s, snap_we_s;
  logic               start_s, stop_s, period_wr_s, timeout_s;
  logic               zero_s, cont_eff_s, run_nxt_s;
  logic [NW-1:0]      period_we_s;
  logic [COUNT_W-1:0] count_s;
  logic [DATA_W-1:0]  rd_mux_s;
  status_t            status_s;

  logic               run_r, to_r, ito_r, cont_r, tick_r, force_reload_r;
  logic [COUNT_W-1:0] period_r, snap_r;
  logic [DATA_W-1:0]  readdata_r;

  assign wr_s       = chipselect & ~write_n;
  assign stat_we_s  = wr_s & (address == ADDR_STATUS);
  assign ctrl_we_s  = wr_s & (address == ADDR_CONTROL);
  assign snap_we_s  = wr_s & (address >= ADDR_SNAP0) & (address <= ADDR_SNAP_LAST);
  assign start_s    = ctrl_we_s & writedata[START_BIT] & ~ALWAYS_RUN;
  assign stop_s     = ctrl_we_s & writedata[STOP_BIT] & ~ALWAYS_RUN;
  assign cont_eff_s = cont_r | ALWAYS_RUN;
  assign timeout_s  = run_r & zero_s;
  assign period_wr_s = |period_we_s;

  // Per-word period write enables; a fixed-period build never enables them.
  always_comb begin
    period_we_s = '0;
    for (int i = 0; i < NW; i++) begin
      period_we_s[i] = wr_s & (address == ADDR_PERIOD0 + 4'(i)) & ~FIXED_PERIOD;
    end
  end

  // Run flag: STOP and period writes beat START, START beats a one-shot expiry.
  always_comb begin
    run_nxt_s = run_r;
    if (ALWAYS_RUN) begin
      run_nxt_s = 1'b1;
    end else if (stop_s || period_wr_s) begin
      run_nxt_s = 1'b0;
    end else if (start_s) begin
      run_nxt_s = 1'b1;
    end else if (timeout_s && !cont_eff_s) begin
      run_nxt_s = 1'b0;
    end else begin
      run_nxt_s = run_r;
    end
  end

  // Control/status flops; a timeout in the same cycle as a status write keeps TO set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_r          <= 1'b0;
      to_r           <= 1'b0;
      ito_r          <= 1'b0;
      cont_r         <= 1'b0;
      tick_r         <= 1'b0;
      force_reload_r <= 1'b0;
    end else begin
      run_r          <= run_nxt_s;
      tick_r         <= timeout_s;
      force_reload_r <= period_wr_s;
      if (timeout_s) begin
        to_r <= 1'b1;
      end else if (stat_we_s) begin
        to_r <= 1'b0;
      end else begin
        to_r <= to_r;
      end
      if (ctrl_we_s) begin
        ito_r  <= writedata[ITO_BIT];
        cont_r <= writedata[CONT_BIT];
      end else begin
        ito_r  <= ito_r;
        cont_r <= cont_r;
      end
    end
  end

  // Period words and the coherent counter snapshot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period_r <= RST_PERIOD;
      snap_r   <= '0;
    end else begin
      for (int i = 0; i < NW; i++) begin
        if (period_we_s[i]) begin
          period_r[i*DATA_W +: DATA_W] <= writedata;
        end else begin
          period_r[i*DATA_W +: DATA_W] <= period_r[i*DATA_W +: DATA_W];
        end
      end
      if (snap_we_s) begin
        snap_r <= count_s;
      end else begin
        snap_r <= snap_r;
      end
    end
  end

  // The counter picks up period_r one cycle after a period write, so a full multi-word value lands.
  timer_gen2_counter #(
    .COUNT_W     (COUNT_W),
    .RESET_VALUE (RST_PERIOD)
  ) u_counter (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (force_reload_r | timeout_s),
    .enable     (run_r),
    .load_value (period_r),
    .count      (count_s),
    .zero       (zero_s)
  );

  assign status_s.run = run_r;
  assign status_s.to  = to_r;

  // Read mux; unmapped addresses fall through to zero.
  always_comb begin
    rd_mux_s = '0;
    case (address)
      ADDR_STATUS: begin
        rd_mux_s[TO_BIT]  = status_s.to;
        rd_mux_s[RUN_BIT] = status_s.run;
      end
      ADDR_CONTROL: begin
        rd_mux_s[ITO_BIT]  = ito_r;
        rd_mux_s[CONT_BIT] = cont_eff_s;
      end
      default: begin
        for (int i = 0; i < NW; i++) begin
          rd_mux_s = rd_mux_s
                   | ((address == ADDR_PERIOD0 + 4'(i)) ? period_r[i*DATA_W +: DATA_W] : '0)
                   | ((address == ADDR_SNAP0 + 4'(i))   ? snap_r[i*DATA_W +: DATA_W]   : '0);
        end
      end
    endcase
  end

  // Registered read data, one cycle after the address.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata_r <= '0;
    end else begin
      readdata_r <= rd_mux_s;
    end
  end

  assign readdata = readdata_r;
  assign tick_out = tick_r;
  assign irq      = to_r & ito_r;

endmodule

// File: tb/tb_avalon_interval_timer_gen2.sv
// Directed plus randomized bench for avalon_interval_timer_gen2 against an arithmetic timeline model.
module tb_avalon_interval_timer_gen2;

  localparam logic [3:0] A_STAT = 4'd0;
  localparam logic [3:0] A_CTRL = 4'd1;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  address;
  logic [3:0]  cs;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] rd_a, rd_b, rd_c, rd_d;
  logic        irq_a, irq_b, irq_c, irq_d;
  logic        tick_a, tick_b, tick_c, tick_d;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total    = 0;
  int cyc      = 0;
  int rel_cyc  = 0;
  int tick_cnt_b = 0;
  int tick_cnt_c = 0;
  int tickq_a[$];

  always #5 clk = ~clk;

  avalon_interval_timer_gen2 #(.COUNT_W(32), .DATA_W(16), .RESET_PERIOD(64'd9),
    .FIXED_PERIOD(1'b0), .ALWAYS_RUN(1'b1)) dut_a (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs[0]), .write_n(write_n),
    .writedata(writedata), .readdata(rd_a), .irq(irq_a), .tick_out(tick_a));

  avalon_interval_timer_gen2 #(.COUNT_W(32), .DATA_W(16), .RESET_PERIOD(64'd49999),
    .FIXED_PERIOD(1'b0), .ALWAYS_RUN(1'b0)) dut_b (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs[1]), .write_n(write_n),
    .writedata(writedata), .readdata(rd_b), .irq(irq_b), .tick_out(tick_b));

  avalon_interval_timer_gen2 #(.COUNT_W(64), .DATA_W(16), .RESET_PERIOD(64'h0004_0003_0002_0001),
    .FIXED_PERIOD(1'b0), .ALWAYS_RUN(1'b0)) dut_c (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs[2]), .write_n(write_n),
    .writedata(writedata), .readdata(rd_c), .irq(irq_c), .tick_out(tick_c));

  avalon_interval_timer_gen2 #(.COUNT_W(32), .DATA_W(16), .RESET_PERIOD(64'd30),
    .FIXED_PERIOD(1'b1), .ALWAYS_RUN(1'b0)) dut_d (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs[3]), .write_n(write_n),
    .writedata(writedata), .readdata(rd_d), .irq(irq_d), .tick_out(tick_d));

  always @(posedge clk) cyc <= cyc + 1;

  // Tick monitors, sampled on the falling edge
  always @(negedge clk) begin
    if (tick_a) tickq_a.push_back(cyc - rel_cyc);
    if (tick_b) tick_cnt_b <= tick_cnt_b + 1;
    if (tick_c) tick_cnt_c <= tick_cnt_c + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input int dev, input logic [3:0] a, input logic [15:0] d);
    address   = a;
    writedata = d;
    write_n   = 1'b0;
    cs        = 4'b0001 << dev;
    @(posedge clk);
    #1;
    cs      = 4'b0000;
    write_n = 1'b1;
  endtask

  task automatic bus_read(input int dev, input logic [3:0] a, output logic [15:0] d);
    address = a;
    @(posedge clk);
    #1;
    case (dev)
      0: d = rd_a;
      1: d = rd_b;
      2: d = rd_c;
      default: d = rd_d;
    endcase
  endtask

  // Counter value j cycles after START loaded period p (reload takes one cycle at zero)
  function automatic longint model_val(longint p, bit cont, longint j);
    if (cont) return p - (j % (p + 1));
    return (j <= p) ? p - j : p;
  endfunction

  // Number of timeouts within the first k cycles after START
  function automatic longint model_tos(longint p, bit cont, longint k);
    longint n;
    n = k / (p + 1);
    if (cont) return n;
    return (n > 0) ? 1 : 0;
  endfunction

  task automatic run_case(input string tag, input logic [31:0] p, input bit cont, input bit ito,
                          input int m);
    logic [15:0] d;
    longint      snap, exp_ticks;
    int          base;
    bit          exp_to, exp_run;
    bus_write(1, A_CTRL, 16'h0008);
    bus_write(1, A_STAT, 16'h0000);
    bus_write(1, 4'd2, p[15:0]);
    bus_write(1, 4'd3, p[31:16]);
    bus_write(1, A_CTRL, {12'd0, 1'b0, 1'b1, cont, ito});
    base = tick_cnt_b;
    repeat (m) @(posedge clk);
    bus_write(1, 4'd4, 16'h1234);
    exp_ticks = model_tos(longint'(p), cont, longint'(m));
    exp_to    = model_tos(longint'(p), cont, longint'(m)) > 0;
    check({tag, "_ticks"}, 64'(tick_cnt_b - base), 64'(exp_ticks));
    check({tag, "_irq"}, {63'd0, irq_b}, {63'd0, exp_to & ito});
    exp_to  = model_tos(longint'(p), cont, longint'(m + 1)) > 0;
    exp_run = cont ? 1'b1 : ((m + 1) < (longint'(p) + 1));
    bus_read(1, A_STAT, d);
    check({tag, "_status"}, {48'd0, d}, {62'd0, exp_run, exp_to});
    snap = model_val(longint'(p), cont, longint'(m));
    bus_read(1, 4'd4, d);
    check({tag, "_snap0"}, {48'd0, d}, {48'd0, snap[15:0]});
    bus_read(1, 4'd5, d);
    check({tag, "_snap1"}, {48'd0, d}, {48'd0, snap[31:16]});
  endtask

  initial begin
    logic [15:0] d;
    int          guard;
    int          base;
    reset_n   = 1'b0;
    address   = 4'd0;
    cs        = 4'b0000;
    write_n   = 1'b1;
    writedata = 16'd0;
    #1;
    check("rst_readdata", {48'd0, rd_b}, 64'd0);
    check("rst_irq_tick", {62'd0, irq_b, tick_b}, 64'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    rel_cyc = cyc;

    // Reset state of the plain timer
    bus_read(1, A_STAT, d);    check("rst_status", {48'd0, d}, 64'd0);
    bus_read(1, A_CTRL, d);    check("rst_control", {48'd0, d}, 64'd0);
    bus_read(1, 4'd2, d);      check("rst_period0", {48'd0, d}, 64'hC34F);
    bus_read(1, 4'd3, d);      check("rst_period1", {48'd0, d}, 64'd0);
    bus_read(1, 4'd4, d);      check("rst_snap0", {48'd0, d}, 64'd0);
    bus_read(1, 4'hF, d);      check("unmapped", {48'd0, d}, 64'd0);

    // Always-run timer: first tick 11 cycles after release, then every 10
    guard = 0;
    while (tickq_a.size() < 3 && guard < 200) begin
      @(posedge clk);
      guard++;
    end
    check("ar_tick_count", 64'(tickq_a.size() >= 3), 64'd1);
    if (tickq_a.size() >= 3) begin
      check("ar_tick0", 64'(tickq_a[0]), 64'd11);
      check("ar_tick1", 64'(tickq_a[1]), 64'd21);
      check("ar_tick2", 64'(tickq_a[2]), 64'd31);
    end
    bus_read(0, A_STAT, d);    check("ar_status", {48'd0, d}, 64'h3);
    bus_read(0, A_CTRL, d);    check("ar_cont_forced", {48'd0, d}, 64'h2);
    bus_write(0, A_CTRL, 16'h0008);
    bus_read(0, A_STAT, d);    check("ar_stop_ignored", {63'd0, d[1]}, 64'd1);

    // One-shot period 4 with ITO off, then enable ITO, then clear
    run_case("oneshot4", 32'd4, 1'b0, 1'b0, 20);
    bus_write(1, A_CTRL, 16'h0001);
    check("irq_after_ito", {63'd0, irq_b}, 64'd1);
    bus_write(1, A_STAT, 16'h0000);
    check("irq_after_clear", {63'd0, irq_b}, 64'd0);

    // Two-word period and snapshot
    run_case("p10000", 32'h0001_0000, 1'b1, 1'b1, 100);
    run_case("period0_cont", 32'd0, 1'b1, 1'b1, 7);
    run_case("period0_once", 32'd0, 1'b0, 1'b1, 7);
    for (int i = 0; i < 6; i++) begin
      run_case("rand", 32'($urandom_range(0, 40)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), int'($urandom_range(0, 120)));
    end

    // Status clear exactly on the timeout edge: set wins
    bus_write(1, A_CTRL, 16'h0008);
    bus_write(1, A_STAT, 16'h0000);
    bus_write(1, 4'd2, 16'd20);
    bus_write(1, 4'd3, 16'd0);
    bus_write(1, A_CTRL, 16'h0006);
    bus_write(1, A_STAT, 16'h0000);
    bus_read(1, A_STAT, d);    check("clr_before_to", {48'd0, d}, 64'h2);
    repeat (18) @(posedge clk);
    bus_write(1, A_STAT, 16'h0000);
    bus_read(1, A_STAT, d);    check("set_wins", {48'd0, d}, 64'h3);
    bus_write(1, A_CTRL, 16'h000C);
    bus_read(1, A_STAT, d);    check("start_stop", {48'd0, d}, 64'h1);
    bus_read(1, A_CTRL, d);    check("strobes_read0", {48'd0, d}, 64'h0);

    // Fixed period: write ignored, no stop, no reload
    bus_write(3, A_CTRL, 16'h0006);
    bus_write(3, 4'd2, 16'h0005);
    repeat (2) @(posedge clk);
    bus_write(3, 4'd4, 16'h0000);
    bus_read(3, 4'd2, d);      check("fixed_period0", {48'd0, d}, 64'd30);
    bus_read(3, 4'd3, d);      check("fixed_period1", {48'd0, d}, 64'd0);
    bus_read(3, A_STAT, d);    check("fixed_running", {48'd0, d}, 64'h2);
    bus_read(3, 4'd4, d);      check("fixed_snap0", {48'd0, d}, 64'd27);

    // 64-bit timer: run, then a one-cycle reset mid-count
    bus_write(2, 4'd2, 16'd3);
    bus_write(2, 4'd3, 16'd0);
    bus_write(2, 4'd4, 16'd0);
    bus_write(2, 4'd5, 16'd0);
    bus_write(2, A_CTRL, 16'h0007);
    repeat (20) @(posedge clk);
    check("w64_irq", {63'd0, irq_c}, 64'd1);
    bus_write(2, 4'd6, 16'd0);
    bus_read(2, 4'd2, d);      check("w64_period0", {48'd0, d}, 64'd3);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("mid_rst_readdata", {48'd0, rd_c}, 64'd0);
    check("mid_rst_irq_tick", {62'd0, irq_c, tick_c}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    base = tick_cnt_c;
    bus_read(2, A_STAT, d);    check("w64_rst_status", {48'd0, d}, 64'd0);
    bus_read(2, A_CTRL, d);    check("w64_rst_control", {48'd0, d}, 64'd0);
    for (int i = 0; i < 4; i++) begin
      bus_read(2, 4'(2 + i), d);
      check("w64_rst_period", {48'd0, d}, 64'(i + 1));
      bus_read(2, 4'(6 + i), d);
      check("w64_rst_snap", {48'd0, d}, 64'd0);
    end
    check("w64_no_tick", 64'(tick_cnt_c - base), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
